led_blink_pio: RTL and testbench

// Avalon-MM slave output PIO for the DE2-115 board LEDs; the output counterpart of the switch input PIO.
// The Nios II writes the LED pattern directly or via atomic set/clear registers.
// A per-bit blink engine toggles selected LEDs at a software-programmed half-period with no CPU involvement.

---
 rtl/led_blink_pio.sv | 110 +++++++++++
 tb/tb_led_blink_pio.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_blink_pio.sv
// Avalon-MM output PIO for board LEDs: DATA with atomic set/clear plus a per-bit blink engine.
// Read latency 1, writes land on the addressed edge, no wait states; out_port is a pure function of registers.
module led_blink_pio #(
  parameter int unsigned WIDTH       = 18,
  parameter logic [31:0] RESET_VALUE = 32'd0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_MSK    = 3'd1;
  localparam logic [2:0] A_HALF   = 3'd2;
  localparam logic [2:0] A_SET    = 3'd4;
  localparam logic [2:0] A_CLR    = 3'd5;
  localparam logic [2:0] A_STATUS = 3'd6;

  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] blink_msk;
  logic [31:0]      half_per;
  logic [31:0]      cnt;
  logic             phase;

  logic             wr_en;
  logic [WIDTH-1:0] wd;
  logic             restart;
  logic             term_cnt;
  logic [31:0]      data_ext;
  logic [31:0]      msk_ext;
  logic [31:0]      rd_mux;
  logic             unused_bits;

  assign wr_en       = chipselect & ~write_n;
  assign wd          = writedata[WIDTH-1:0];
  assign unused_bits = ^writedata;

  // A HALF_PER write always restarts, so a smaller period can never leave cnt past the terminal count.
  assign restart  = wr_en && ((address == A_HALF) || ((address == A_STATUS) && writedata[0]));
  assign term_cnt = (cnt == (half_per - 32'd1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= RESET_VALUE[WIDTH-1:0];
    end else if (wr_en) begin
      case (address)
        A_DATA:  data <= wd;
        A_SET:   data <= data | wd;
        A_CLR:   data <= data & ~wd;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_msk <= '0;
      half_per  <= '0;
    end else if (wr_en) begin
      if (address == A_MSK) blink_msk <= wd;
      if (address == A_HALF) half_per <= writedata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (restart || (half_per == 32'd0)) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (term_cnt) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + 32'd1;
    end
  end

  always_comb begin
    data_ext              = '0;
    data_ext[WIDTH-1:0]   = data;
    msk_ext               = '0;
    msk_ext[WIDTH-1:0]    = blink_msk;
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      A_DATA:   rd_mux = data_ext;
      A_MSK:    rd_mux = msk_ext;
      A_HALF:   rd_mux = half_per;
      A_STATUS: rd_mux = {31'd0, phase};
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

  assign out_port = data & ~(blink_msk & {WIDTH{phase}});

endmodule

// File: tb/tb_led_blink_pio.sv
// Bench for led_blink_pio: directed tables and sequences plus random traffic against a timing model.
module tb_led_blink_pio;

  localparam int unsigned WIDTH = 18;
  localparam logic [31:0] RESET_VALUE = 32'd0;
  localparam logic [31:0] MASK = 32'h0003_FFFF;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [2:0]       address = '0;
  logic             chipselect = 1'b0;
  logic             write_n = 1'b1;
  logic [31:0]      writedata = '0;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] out_port;

  int checks = 0;
  int failures = 0;

  // Model: registers plus the number of edges since the last blink restart.
  logic [31:0]     m_data, m_msk, m_hp, m_rd;
  longint unsigned m_t;

  led_blink_pio #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp_out;
    logic [31:0] exp_rd;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_phase();
    if (m_hp == 0) return 1'b0;
    return ((m_t / longint'(m_hp)) % 2) == 1;
  endfunction

  function automatic logic [31:0] m_out();
    return m_data & ~(m_msk & {32{m_phase()}});
  endfunction

  task automatic model_reset();
    m_data = RESET_VALUE & MASK;
    m_msk  = '0;
    m_hp   = '0;
    m_rd   = '0;
    m_t    = 0;
  endtask

  task automatic model_step(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] wd);
    logic rs;
    rs = 1'b0;
    case (a)
      3'd0:    m_rd = m_data;
      3'd1:    m_rd = m_msk;
      3'd2:    m_rd = m_hp;
      3'd6:    m_rd = {31'd0, m_phase()};
      default: m_rd = '0;
    endcase
    if (cs && !wn) begin
      case (a)
        3'd0: m_data = wd & MASK;
        3'd1: m_msk  = wd & MASK;
        3'd2: begin m_hp = wd; rs = 1'b1; end
        3'd4: m_data = m_data | (wd & MASK);
        3'd5: m_data = m_data & ~wd & MASK;
        3'd6: rs = wd[0];
        default: ;
      endcase
    end
    if (rs || m_hp == 0) m_t = 0;
    else                 m_t = m_t + 1;
  endtask

  task automatic cycle(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] wd);
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
    @(posedge clk);
    model_step(cs, wn, a, wd);
    #1;
    check("model_out", {14'd0, out_port}, m_out());
    check("model_rd", readdata, m_rd);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] wd);
    cycle(1'b1, 1'b0, a, wd);
  endtask

  task automatic idle(input logic [2:0] a);
    cycle(1'b0, 1'b1, a, 32'd0);
  endtask

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{1'b1, 3'd0, 32'h10,       32'h10, 32'h0};
    vecs[1]  = '{1'b1, 3'd4, 32'h5,        32'h15, 32'h0};
    vecs[2]  = '{1'b0, 3'd0, 32'h0,        32'h15, 32'h15};
    vecs[3]  = '{1'b1, 3'd5, 32'h4,        32'h11, 32'h0};
    vecs[4]  = '{1'b0, 3'd0, 32'h0,        32'h11, 32'h11};
    vecs[5]  = '{1'b0, 3'd3, 32'h0,        32'h11, 32'h0};
    vecs[6]  = '{1'b0, 3'd4, 32'h0,        32'h11, 32'h0};
    vecs[7]  = '{1'b0, 3'd5, 32'h0,        32'h11, 32'h0};
    vecs[8]  = '{1'b0, 3'd7, 32'h0,        32'h11, 32'h0};
    vecs[9]  = '{1'b1, 3'd3, 32'hFFFF,     32'h11, 32'h0};
    vecs[10] = '{1'b1, 3'd7, 32'hFF,       32'h11, 32'h0};
    vecs[11] = '{1'b0, 3'd3, 32'h0,        32'h11, 32'h0};
    vecs[12] = '{1'b1, 3'd4, 32'hFFFC0000, 32'h11, 32'h0};
    vecs[13] = '{1'b0, 3'd0, 32'h0,        32'h11, 32'h11};
    vecs[14] = '{1'b0, 3'd1, 32'h0,        32'h11, 32'h0};
    vecs[15] = '{1'b0, 3'd2, 32'h0,        32'h11, 32'h0};

    model_reset();
    // T1: reset values and full-width write truncation
    #12;
    check("reset_out", {14'd0, out_port}, RESET_VALUE & MASK);
    check("reset_rd", readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    wr(3'd0, 32'hFFFF_FFFF);
    check("t1_out", {14'd0, out_port}, 32'h0003_FFFF);
    idle(3'd0);
    check("t1_rd", readdata, 32'h0003_FFFF);

    // T2: set/clear and reserved addresses
    foreach (vecs[i]) begin
      cycle(1'b1, !vecs[i].wr, vecs[i].addr, vecs[i].wd);
      check($sformatf("t2_out[%0d]", i), {14'd0, out_port}, vecs[i].exp_out);
      if (!vecs[i].wr) check($sformatf("t2_rd[%0d]", i), readdata, vecs[i].exp_rd);
    end

    // T3: blink with half-period 4, STATUS tracking phase
    wr(3'd0, 32'hFF);
    wr(3'd1, 32'h0F);
    wr(3'd2, 32'd4);
    check("t3_start", {14'd0, out_port}, 32'hFF);
    for (int k = 1; k <= 16; k++) begin
      idle(3'd6);
      check($sformatf("t3_out[%0d]", k), {14'd0, out_port}, (((k / 4) % 2) == 1) ? 32'hF0 : 32'hFF);
      check($sformatf("t3_status[%0d]", k), readdata, 32'((((k - 1) / 4) % 2)));
    end

    // T4: disable while in phase 1
    for (int k = 0; k < 4; k++) idle(3'd6);
    check("t4_phase1", {14'd0, out_port}, 32'hF0);
    wr(3'd2, 32'd0);
    for (int k = 0; k < 100; k++) begin
      idle(3'd6);
      check("t4_hold", {14'd0, out_port}, 32'hFF);
    end
    check("t4_status", readdata, 32'd0);

    // T5: restart collides with terminal count
    wr(3'd2, 32'd3);
    idle(3'd0);
    idle(3'd0);
    wr(3'd6, 32'd1);
    check("t5_collide", {14'd0, out_port}, 32'hFF);
    idle(3'd0);
    check("t5_c1", {14'd0, out_port}, 32'hFF);
    idle(3'd0);
    check("t5_c2", {14'd0, out_port}, 32'hFF);
    idle(3'd0);
    check("t5_toggle", {14'd0, out_port}, 32'hF0);

    // T6: asynchronous reset with phase=1, cnt=2
    wr(3'd2, 32'd4);
    for (int k = 0; k < 6; k++) idle(3'd0);
    check("t6_pre_out", {14'd0, out_port}, 32'hF0);
    check("t6_pre_cnt", dut.cnt, 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_out", {14'd0, out_port}, RESET_VALUE & MASK);
    check("t6_cnt", dut.cnt, 32'd0);
    check("t6_phase", {31'd0, dut.phase}, 32'd0);
    check("t6_rd", readdata, 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    idle(3'd1);
    check("t6_msk", readdata, 32'd0);
    idle(3'd2);
    check("t6_hp", readdata, 32'd0);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic        cs, wn;
      logic [2:0]  a;
      logic [31:0] d;
      cs = ($urandom_range(0, 3) != 0);
      wn = ($urandom_range(0, 2) != 0);
      a  = 3'($urandom_range(0, 7));
      d  = $urandom;
      if (a == 3'd2) d = $urandom_range(0, 7);
      if (a == 3'd0 && $urandom_range(0, 9) == 0) d = 32'd0;
      cycle(cs, wn, a, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
